seq_cascade_comparator: RTL and testbench
=========================================

Name: seq_cascade_comparator

Overview:
Sequential magnitude comparator for unsigned WIDTH-bit operands. Processes DIGIT bits per clock, MSB-first, using a cascade cell. Carries eq/gt cascade inputs from a more-significant stage, so instances chain for wider words. Used where a full-width combinational compare chain is too slow or too large. Start/done handshake; result held until the next start.

Parameters:
WIDTH, 8, operand width in bits (>=1)
DIGIT, 2, bits compared per cycle (1..WIDTH)
NDIG, ceil(WIDTH/DIGIT), derived local constant: digit count, not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
a  input  WIDTH  operand A, sampled on accepted start
b  input  WIDTH  operand B, sampled on accepted start
eq_in  input  1  cascade: more-significant bits equal; sampled with start
gt_in  input  1  cascade: more-significant bits A>B; sampled with start
busy  output  1  comparison in progress
done  output  1  one-cycle pulse, result valid
eq_out  output  1  A==B including cascade
gt_out  output  1  A>B including cascade
lt_out  output  1  A<B including cascade

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, eq_out=1, gt_out=0, lt_out=0; digit counter=0.
- States: IDLE, CMP, DONE.
- IDLE + start=1 at edge k:
  - latch a, b, eq_in, gt_in;
  - zero-pad LSB end to NDIG*DIGIT bits (padding is equal, so it has no effect);
  - go to CMP; busy=1 from edge k.
- CMP, edge k+1+i: digit i (i=0 is MSB digit) goes through the cascade cell using the running (eq, gt).
  - Running (eq, gt) is initialised from (eq_in, gt_in).
  - Cell rule: if eq=0, state is held. Otherwise digit_a>digit_b gives (0,1), digit_a<digit_b gives (0,0), equal gives (1,0).
- After the last digit, go to DONE; eq_out/gt_out/lt_out update on the same edge; lt_out = ~eq & ~gt.
- DONE: done=1 for exactly one cycle, busy=0 from that cycle, then IDLE. start in the DONE cycle is ignored.
- Latency (base build): start edge k, done high in the cycle after edge k+NDIG.
- start while busy=1: ignored; operands and result are unaffected.
- Invalid cascade eq_in=1 & gt_in=1: treated as eq_in=1 (gt_in ignored).
- Result outputs change only on the DONE transition. They hold between operations and during the next comparison.
- Reset mid-operation: abort immediately; outputs return to reset values; no done pulse.

Optional Feature:
Macro: SEQ_CMP_EARLY_EXIT_EN.
- Defined: CMP goes to DONE on the first edge where running eq becomes 0, including eq_in=0 at start, which gives a single CMP cycle. Latency ranges from 1 to NDIG cycles.
- Undefined: latency is always NDIG cycles.
- Results are identical in both builds.

Decomposition:
- Package seq_cmp_pkg holds:
  - state enum (IDLE/CMP/DONE);
  - ndig(width, digit) ceil function;
  - reset-value constants for eq/gt.
- One sub-module, cmp_digit_cell: combinational DIGIT-bit cascade cell. Inputs a_d, b_d, eq_i, gt_i; outputs eq_o, gt_o.

Test Plan:
- WIDTH=8, DIGIT=2, a=0, b=0, eq_in=1, gt_in=0 -> eq_out=1, gt_out=0, lt_out=0; done pulse 4 cycles after start edge (both builds).
- a=128, b=0 -> gt_out=1; base build: done after 4 cycles; EARLY_EXIT build: done after 1 cycle. Swapped (a=0, b=128) -> lt_out=1.
- eq_in=0, gt_in=1, a=0, b=255 -> gt_out=1, lt_out=0 (cascade dominates); EARLY_EXIT build: latency 1.
- Second start while busy with a=5, b=9 -> ignored; first result reported; one done pulse only.
- rst_n low at the 2nd CMP cycle -> busy=0, eq_out=1, no done pulse; a fresh start after release completes correctly.
- Exhaustive 256x256 (WIDTH=8, DIGIT=2) and WIDTH=7, DIGIT=3 (padding case) vs behavioural compare -> all eq/gt/lt match.

Source files
------------

// File: rtl/seq_cmp_pkg.sv
// Shared types and constants for the sequential cascade comparator.
//   state_t : comparator FSM states
//   ndig()  : number of DIGIT-bit digits needed to cover WIDTH bits
//   EQ_RST / GT_RST : result values presented after reset
package seq_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic EQ_RST = 1'b1;
    localparam logic GT_RST = 1'b0;

    // Ceiling division; the operand is zero-padded up to ndig*digit bits
    function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
        return (width + digit - 1) / digit;
    endfunction

endpackage

// File: rtl/cmp_digit_cell.sv
// Combinational DIGIT-bit magnitude cascade cell.
//   a_d, b_d : digit of operand A / B
//   eq_i     : more-significant digits equal so far
//   gt_i     : more-significant digits decided A>B (only meaningful when eq_i=0)
//   eq_o     : equality after this digit
//   gt_o     : A>B after this digit
module cmp_digit_cell #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             eq_i,
    input  logic             gt_i,
    output logic             eq_o,
    output logic             gt_o
);

    // Once a more-significant digit has decided the order, lower digits cannot change it
    always_comb begin
        eq_o = eq_i;
        gt_o = gt_i;
        if (eq_i) begin
            if (a_d > b_d) begin
                eq_o = 1'b0;
                gt_o = 1'b1;
            end else if (a_d < b_d) begin
                eq_o = 1'b0;
                gt_o = 1'b0;
            end else begin
                eq_o = 1'b1;
                gt_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_cascade_comparator.sv
// Sequential MSB-first magnitude comparator for unsigned WIDTH-bit operands,
// DIGIT bits per clock, chainable through eq_in/gt_in.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, a, b     : request and operands, accepted only when idle
//   eq_in, gt_in    : cascade from a more-significant stage (eq_in wins if both set)
//   busy            : comparison in progress
//   done            : one-cycle pulse, results valid
//   eq_out/gt_out/lt_out : registered result, held until the next completion
// Build option: define SEQ_CMP_EARLY_EXIT_EN to finish as soon as the order is decided.
module seq_cascade_comparator
    import seq_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             eq_in,
    input  logic             gt_in,
    output logic             busy,
    output logic             done,
    output logic             eq_out,
    output logic             gt_out,
    output logic             lt_out
);

    localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
    localparam int unsigned PW   = NDIG * DIGIT;
    localparam int unsigned PAD  = PW - WIDTH;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t          r_state;
    state_t          w_next;
    logic [PW-1:0]   r_a;
    logic [PW-1:0]   r_b;
    logic            r_eq;
    logic            r_gt;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_eq_out;
    logic            r_gt_out;
    logic            r_lt_out;
    logic            w_eq;
    logic            w_gt;
    logic            w_last;

    // Current digit is always the top DIGIT bits; operands shift left each step
    cmp_digit_cell #(.DIGIT(DIGIT)) u_cell (
        .a_d  (r_a[PW-1 -: DIGIT]),
        .b_d  (r_b[PW-1 -: DIGIT]),
        .eq_i (r_eq),
        .gt_i (r_gt),
        .eq_o (w_eq),
        .gt_o (w_gt)
    );

`ifdef SEQ_CMP_EARLY_EXIT_EN
    assign w_last = (r_cnt == LAST) || !w_eq;
`else
    assign w_last = (r_cnt == LAST);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_next = ST_CMP;
            ST_CMP:  if (w_last) w_next = ST_DONE;
            ST_DONE:             w_next = ST_IDLE;
            default:             w_next = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_eq     <= EQ_RST;
            r_gt     <= GT_RST;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_eq_out <= EQ_RST;
            r_gt_out <= GT_RST;
            r_lt_out <= 1'b0;
        end else begin
            r_busy <= (w_next == ST_CMP);
            r_done <= (w_next == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // Zero padding at the LSB end compares equal, so it never affects the result
                        r_a   <= PW'(a) << PAD;
                        r_b   <= PW'(b) << PAD;
                        r_eq  <= eq_in;
                        r_gt  <= gt_in & ~eq_in;
                        r_cnt <= '0;
                    end
                end
                ST_CMP: begin
                    r_a   <= r_a << DIGIT;
                    r_b   <= r_b << DIGIT;
                    r_eq  <= w_eq;
                    r_gt  <= w_gt;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_eq_out <= w_eq;
                        r_gt_out <= w_gt;
                        r_lt_out <= ~w_eq & ~w_gt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign eq_out = r_eq_out;
    assign gt_out = r_gt_out;
    assign lt_out = r_lt_out;

endmodule

// File: tb/tb_seq_cascade_comparator.sv
// Self-checking bench for seq_cascade_comparator: an 8-bit/2-bit-digit instance
// and a 7-bit/3-bit-digit instance (LSB padding), checked against a numeric model.
module tb_seq_cascade_comparator;

`ifdef SEQ_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s8, ei8, gi8, bz8, dn8, eq8, gt8, lt8;
    logic [7:0] a8, b8;
    logic       s7, ei7, gi7, bz7, dn7, eq7, gt7, lt7;
    logic [6:0] a7, b7;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_cascade_comparator #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .eq_in(ei8), .gt_in(gi8),
        .busy(bz8), .done(dn8), .eq_out(eq8), .gt_out(gt8), .lt_out(lt8)
    );

    seq_cascade_comparator #(.WIDTH(7), .DIGIT(3)) dut7 (
        .clk(clk), .rst_n(rst_n), .start(s7), .a(a7), .b(b7), .eq_in(ei7), .gt_in(gi7),
        .busy(bz7), .done(dn7), .eq_out(eq7), .gt_out(gt7), .lt_out(lt7)
    );

    // Reference: numeric compare, cascade dominates unless it says "equal so far"
    function automatic void model(input int w, input int d, input int unsigned av, input int unsigned bv,
                                  input bit ei, input bit gi,
                                  output bit eq, output bit gt, output bit lt, output int lat);
        int nd, pad, early;
        int unsigned pa, pb, da, db, m;
        nd  = (w + d - 1) / d;
        pad = nd * d - w;
        pa  = av << pad;
        pb  = bv << pad;
        m   = 32'd1 << d;
        if (!ei) begin
            eq = 1'b0;
            gt = gi;
            early = 1;
        end else begin
            eq = (av == bv);
            gt = (av > bv);
            early = nd;
            for (int i = 0; i < nd; i++) begin
                da = (pa >> ((nd - 1 - i) * d)) % m;
                db = (pb >> ((nd - 1 - i) * d)) % m;
                if (da != db) begin
                    early = i + 1;
                    break;
                end
            end
        end
        lt  = !eq && !gt;
        lat = EARLY ? early : nd;
    endfunction

    task automatic drive(input int sel, input bit st, input int unsigned av, input int unsigned bv,
                         input bit ei, input bit gi);
        if (sel == 8) begin
            s8 = st; a8 = 8'(av); b8 = 8'(bv); ei8 = ei; gi8 = gi;
        end else begin
            s7 = st; a7 = 7'(av); b7 = 7'(bv); ei7 = ei; gi7 = gi;
        end
    endtask

    function automatic logic [4:0] outs(input int sel);
        return (sel == 8) ? {bz8, dn8, eq8, gt8, lt8} : {bz7, dn7, eq7, gt7, lt7};
    endfunction

    // One operation from idle; lat=0 means no done within the bound. Returns in idle.
    task automatic do_op(input int sel, input int unsigned av, input int unsigned bv, input bit ei, input bit gi,
                         output bit eo, output bit go, output bit lo, output int lat, output bit done_after);
        logic [4:0] o;
        drive(sel, 1'b1, av, bv, ei, gi);
        @(posedge clk); #1;
        drive(sel, 1'b0, av, bv, ei, gi);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            o = outs(sel);
            if (o[3]) begin
                lat = c;
                break;
            end
        end
        o  = outs(sel);
        eo = o[2]; go = o[1]; lo = o[0];
        @(posedge clk); #1;
        o = outs(sel);
        done_after = o[3];
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(8, 1'b0, 0, 0, 1'b1, 1'b0);
        drive(7, 1'b0, 0, 0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outs(8) !== 5'b00100) begin
            errors++;
            $display("FAIL reset8: {busy,done,eq,gt,lt} got %b want 00100", outs(8));
        end
        checks++;
        if (outs(7) !== 5'b00100) begin
            errors++;
            $display("FAIL reset7: {busy,done,eq,gt,lt} got %b want 00100", outs(7));
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        int unsigned ta [6] = '{0, 128, 0, 0, 3, 200};
        int unsigned tb [6] = '{0, 0, 128, 255, 3, 201};
        bit tei [6] = '{1, 1, 1, 0, 1, 1};
        bit tgi [6] = '{0, 0, 0, 1, 1, 1};
        bit eo, go, lo, da, xe, xg, xl;
        int lat, xlat;
        for (int i = 0; i < 6; i++) begin
            model(8, 2, ta[i], tb[i], tei[i], tgi[i], xe, xg, xl, xlat);
            do_op(8, ta[i], tb[i], tei[i], tgi[i], eo, go, lo, lat, da);
            checks++;
            if ({eo, go, lo} !== {xe, xg, xl}) begin
                errors++;
                $display("FAIL directed%0d_result: eq/gt/lt got %b%b%b want %b%b%b", i, eo, go, lo, xe, xg, xl);
            end
            checks++;
            if (lat != xlat) begin
                errors++;
                $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, xlat);
            end
            checks++;
            if (da !== 1'b0) begin
                errors++;
                $display("FAIL directed%0d_done_pulse: done after pulse got %b want 0", i, da);
            end
        end
    endtask

    task automatic test_busy_start;
        int npulse;
        bit rg, re, rl, eo, go, lo, da;
        int lat, xlat;
        bit xe, xg, xl;
        // A second start while busy must be ignored
        drive(8, 1'b1, 128, 0, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(8, 1'b1, 5, 9, 1'b1, 1'b0);
        npulse = 0;
        rg = 1'b0; re = 1'b1; rl = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (c == 0) s8 = 1'b0;
            if (dn8) begin
                npulse++;
                re = eq8; rg = gt8; rl = lt8;
            end
        end
        checks++;
        if (npulse != 1) begin
            errors++;
            $display("FAIL busy_start_pulses: got %0d want 1", npulse);
        end
        checks++;
        if ({re, rg, rl} !== 3'b010) begin
            errors++;
            $display("FAIL busy_start_result: eq/gt/lt got %b%b%b want 010", re, rg, rl);
        end

        // Start during the done cycle must be ignored
        drive(8, 1'b1, 0, 0, 1'b1, 1'b0);
        @(posedge clk); #1;
        s8 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (dn8) break;
        end
        drive(8, 1'b1, 77, 1, 1'b1, 1'b0);
        @(posedge clk); #1;
        s8 = 1'b0;
        checks++;
        if ({bz8, dn8} !== 2'b00) begin
            errors++;
            $display("FAIL done_cycle_start: busy/done got %b%b want 00", bz8, dn8);
        end

        // Previous result (equal) must hold during the next comparison
        drive(8, 1'b1, 5, 9, 1'b1, 1'b0);
        @(posedge clk); #1;
        s8 = 1'b0;
        checks++;
        if ({bz8, eq8, gt8, lt8} !== 4'b1100) begin
            errors++;
            $display("FAIL result_hold: busy/eq/gt/lt got %b want 1100", {bz8, eq8, gt8, lt8});
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (dn8) break;
        end
        checks++;
        if ({eq8, gt8, lt8} !== 3'b001) begin
            errors++;
            $display("FAIL hold_next_result: eq/gt/lt got %b want 001", {eq8, gt8, lt8});
        end
        @(posedge clk); #1;

        // Reset in the 2nd CMP cycle aborts with reset outputs and no done
        drive(8, 1'b1, 1, 2, 1'b1, 1'b0);
        @(posedge clk); #1;
        s8 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs(8) !== 5'b00100) begin
            errors++;
            $display("FAIL reset_mid: {busy,done,eq,gt,lt} got %b want 00100", outs(8));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        npulse = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (dn8) npulse++;
        end
        checks++;
        if (npulse != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d pulses want 0", npulse);
        end
        model(8, 2, 1, 2, 1'b1, 1'b0, xe, xg, xl, xlat);
        do_op(8, 1, 2, 1'b1, 1'b0, eo, go, lo, lat, da);
        checks++;
        if ({eo, go, lo, lat} !== {xe, xg, xl, xlat}) begin
            errors++;
            $display("FAIL after_reset_op: eq/gt/lt/lat got %b%b%b/%0d want %b%b%b/%0d",
                     eo, go, lo, lat, xe, xg, xl, xlat);
        end
    endtask

    task automatic test_corners;
        int unsigned v8 [6] = '{0, 1, 127, 128, 254, 255};
        int unsigned v7 [6] = '{0, 1, 63, 64, 126, 127};
        bit eo, go, lo, da, xe, xg, xl;
        int lat, xlat;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++) begin
                    int sel;
                    int unsigned av, bv;
                    sel = (s == 0) ? 8 : 7;
                    av  = (s == 0) ? v8[i] : v7[i];
                    bv  = (s == 0) ? v8[j] : v7[j];
                    model((s == 0) ? 8 : 7, (s == 0) ? 2 : 3, av, bv, 1'b1, 1'b0, xe, xg, xl, xlat);
                    do_op(sel, av, bv, 1'b1, 1'b0, eo, go, lo, lat, da);
                    checks++;
                    if ({eo, go, lo, lat} !== {xe, xg, xl, xlat}) begin
                        errors++;
                        $display("FAIL corner w%0d a=%0d b=%0d: eq/gt/lt/lat got %b%b%b/%0d want %b%b%b/%0d",
                                 sel, av, bv, eo, go, lo, lat, xe, xg, xl, xlat);
                    end
                end
            end
        end
    endtask

    task automatic test_random;
        bit eo, go, lo, da, xe, xg, xl, ei, gi;
        int lat, xlat, sel, w, d;
        int unsigned av, bv, mask;
        for (int n = 0; n < 2400; n++) begin
            sel  = (n % 2 == 0) ? 8 : 7;
            w    = (sel == 8) ? 8 : 7;
            d    = (sel == 8) ? 2 : 3;
            mask = (32'd1 << w) - 1;
            av   = $urandom & mask;
            bv   = ($urandom_range(7) == 0) ? av : ($urandom & mask);
            ei   = ($urandom_range(3) != 0);
            gi   = 1'($urandom_range(1));
            model(w, d, av, bv, ei, gi, xe, xg, xl, xlat);
            do_op(sel, av, bv, ei, gi, eo, go, lo, lat, da);
            checks++;
            if ({eo, go, lo, lat, da} !== {xe, xg, xl, xlat, 1'b0}) begin
                errors++;
                $display("FAIL random w%0d a=%0d b=%0d ei=%b gi=%b: eq/gt/lt/lat/done got %b%b%b/%0d/%b want %b%b%b/%0d/0",
                         w, av, bv, ei, gi, eo, go, lo, lat, da, xe, xg, xl, xlat);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_busy_start;
        test_corners;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
